// File: rtl/mmc_spi_pkg.sv
// Shared constants for the MMC/SD SPI-mode command responder: FSM codes, R1 layout,
// supported-command set and the CRC7 byte step.
package mmc_spi_pkg;

  typedef logic [2:0] mmcState_t;

  localparam mmcState_t StIdle  = 3'd0;
  localparam mmcState_t StArgs  = 3'd1;
  localparam mmcState_t StCheck = 3'd2;
  localparam mmcState_t StNcr   = 3'd3;
  localparam mmcState_t StResp  = 3'd4;

  // R1 bit positions
  localparam int unsigned R1IdleBit    = 0;
  localparam int unsigned R1IllegalBit = 2;
  localparam int unsigned R1CrcErrBit  = 3;

  localparam logic [7:0] FillByte = 8'hFF;

  // One bit per command index: 0,1,8,9,10,12,13,16,17,24,55,58,59
  localparam logic [63:0] SupportedCmdMask = 64'h0C80_0000_0103_3703;

  // x^7 + x^3 + 1 with the x^7 term implicit
  localparam logic [6:0] Crc7Poly = 7'h09;

  localparam int unsigned ArgBytes = 4;

  function automatic logic isSupported(input logic [5:0] index);
    return SupportedCmdMask[index];
  endfunction

  // Advance a CRC7 by one byte, MSB first
  function automatic logic [6:0] crc7Byte(input logic [6:0] crc, input logic [7:0] data);
    logic [6:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ data[i];
      c  = {c[5:0], 1'b0};
      if (fb) begin
        c = c ^ Crc7Poly;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/mmc_crc7_byte.sv
// Registered CRC7 accumulator, one byte per enabled cycle. Clear together with enable
// restarts the sum from zero with the current byte included.
module mmc_crc7_byte
  import mmc_spi_pkg::*;
(
  input  logic       iCLOCK,
  input  logic       inRESET,
  input  logic       iRESET_SYNC,
  input  logic       iCLEAR,
  input  logic       iENABLE,
  input  logic [7:0] iDATA,
  output logic [6:0] oCRC
);

  logic [6:0] crcQ;
  logic [6:0] crcD;
  logic [6:0] crcBase;

  always_comb begin
    crcBase = iCLEAR ? 7'd0 : crcQ;
    crcD    = crcBase;
    if (iENABLE) begin
      crcD = crc7Byte(crcBase, iDATA);
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      crcQ <= 7'd0;
    end else if (iRESET_SYNC) begin
      crcQ <= 7'd0;
    end else begin
      crcQ <= crcD;
    end
  end

  assign oCRC = crcQ;

endmodule

// File: rtl/mmc_spi_cmd_responder.sv
// SPI-mode MMC/SD command frame decoder: collects six-byte frames, checks CRC7 and the
// supported-command set, then returns R1 after P_NCR filler bytes.
module mmc_spi_cmd_responder
  import mmc_spi_pkg::*;
#(
  parameter int unsigned P_NCR = 1
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iRESET_SYNC,
  input  logic        iMMC_CS,
  input  logic        iMMC_VALID,
  input  logic [7:0]  iMMC_DATA,
  output logic [7:0]  oMMC_DATA,
  input  logic        iIDLE_STATE,
  output logic        oCMD_VALID,
  output logic [5:0]  oCMD_INDEX,
  output logic [31:0] oCMD_ARG
);

  mmcState_t   stateQ, stateD;
  logic [2:0]  byteCntQ, byteCntD;
  logic [3:0]  ncrCntQ, ncrCntD;
  logic [7:0]  dataOutQ, dataOutD;
  logic [5:0]  indexQ, indexD;
  logic [31:0] argQ, argD;
  logic [6:0]  crcRxQ, crcRxD;
  logic        endBitQ, endBitD;
  logic [7:0]  r1Q, r1D;
  logic        crcEnQ, crcEnD;

  logic        crcClear;
  logic        crcEnable;
  logic [6:0]  crcCalc;
  logic        crcActive;
  logic        crcErr;
  logic        illegal;
  logic        cmdOk;
  logic [7:0]  r1Calc;
  logic        frameStart;

  mmc_crc7_byte uCrc (
    .iCLOCK      (iCLOCK),
    .inRESET     (inRESET),
    .iRESET_SYNC (iRESET_SYNC),
    .iCLEAR      (crcClear),
    .iENABLE     (crcEnable),
    .iDATA       (iMMC_DATA),
    .oCRC        (crcCalc)
  );

  // CMD0 and CMD8 are always CRC-checked; everything else only once CMD59 enables it
  assign crcActive = crcEnQ || (indexQ == 6'd0) || (indexQ == 6'd8);
  assign crcErr    = !endBitQ || (crcActive && (crcRxQ != crcCalc));
  assign illegal   = !isSupported(indexQ);
  assign cmdOk     = !crcErr && !illegal;

  always_comb begin
    r1Calc               = 8'h00;
    r1Calc[R1IdleBit]    = iIDLE_STATE;
    r1Calc[R1IllegalBit] = illegal;
    r1Calc[R1CrcErrBit]  = crcErr;
  end

  assign frameStart = iMMC_VALID && (iMMC_DATA[7:6] == 2'b01);

  always_comb begin
    stateD    = stateQ;
    byteCntD  = byteCntQ;
    ncrCntD   = ncrCntQ;
    dataOutD  = dataOutQ;
    indexD    = indexQ;
    argD      = argQ;
    crcRxD    = crcRxQ;
    endBitD   = endBitQ;
    r1D       = r1Q;
    crcEnD    = crcEnQ;
    crcClear  = 1'b0;
    crcEnable = 1'b0;

    if (iMMC_CS) begin
      // Deselect abandons any frame or pending response; crc_en survives
      stateD   = StIdle;
      dataOutD = FillByte;
    end else begin
      case (stateQ)
        StIdle: begin
          dataOutD = FillByte;
          if (frameStart) begin
            indexD    = iMMC_DATA[5:0];
            byteCntD  = 3'd0;
            crcClear  = 1'b1;
            crcEnable = 1'b1;
            stateD    = StArgs;
          end
        end

        StArgs: begin
          if (iMMC_VALID) begin
            if (byteCntQ < 3'(ArgBytes)) begin
              argD      = {argQ[23:0], iMMC_DATA};
              crcEnable = 1'b1;
              byteCntD  = byteCntQ + 3'd1;
            end else begin
              crcRxD  = iMMC_DATA[7:1];
              endBitD = iMMC_DATA[0];
              stateD  = StCheck;
            end
          end
        end

        // Single decision cycle; a stray valid here is simply not looked at
        StCheck: begin
          r1D     = r1Calc;
          ncrCntD = 4'(P_NCR);
          stateD  = StNcr;
          if (cmdOk && (indexQ == 6'd59)) begin
            crcEnD = argQ[0];
          end
        end

        StNcr: begin
          if (iMMC_VALID) begin
            ncrCntD = ncrCntQ - 4'd1;
            if (ncrCntQ <= 4'd1) begin
              dataOutD = r1Q;
              stateD   = StResp;
            end
          end
        end

        StResp: begin
          if (iMMC_VALID) begin
            dataOutD = FillByte;
            stateD   = StIdle;
          end
        end

        default: begin
          stateD   = StIdle;
          dataOutD = FillByte;
        end
      endcase
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      stateQ   <= StIdle;
      byteCntQ <= 3'd0;
      ncrCntQ  <= 4'd0;
      dataOutQ <= FillByte;
      indexQ   <= 6'd0;
      argQ     <= 32'd0;
      crcRxQ   <= 7'd0;
      endBitQ  <= 1'b0;
      r1Q      <= 8'h00;
      crcEnQ   <= 1'b0;
    end else if (iRESET_SYNC) begin
      stateQ   <= StIdle;
      byteCntQ <= 3'd0;
      ncrCntQ  <= 4'd0;
      dataOutQ <= FillByte;
      indexQ   <= 6'd0;
      argQ     <= 32'd0;
      crcRxQ   <= 7'd0;
      endBitQ  <= 1'b0;
      r1Q      <= 8'h00;
      crcEnQ   <= 1'b0;
    end else begin
      stateQ   <= stateD;
      byteCntQ <= byteCntD;
      ncrCntQ  <= ncrCntD;
      dataOutQ <= dataOutD;
      indexQ   <= indexD;
      argQ     <= argD;
      crcRxQ   <= crcRxD;
      endBitQ  <= endBitD;
      r1Q      <= r1D;
      crcEnQ   <= crcEnD;
    end
  end

  assign oCMD_VALID = (stateQ == StCheck) && cmdOk && !iMMC_CS && !iRESET_SYNC;
  assign oMMC_DATA  = dataOutQ;
  assign oCMD_INDEX = indexQ;
  assign oCMD_ARG   = argQ;

endmodule
